id_stage: RTL and testbench

Instruction-decode stage of the basic in-order MIPS pipeline, placed between fetch and execute. It accepts one instruction per cycle from fetch, decodes it, reads operands from the register file's two combinational read ports, and resolves RAW/WAW hazards with a per-register scoreboard plus a writeback bypass. Decoded operands are registered into the ID/EX pipeline register behind a valid/ready handshake. The writeback stage drives the register file write port and reports each completed write back to this block, which clears the matching scoreboard entry.

---
 rtl/id_stage.sv | 223 ++++++++++++++++++++++
 tb/tb_id_stage.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// id_stage: MIPS instruction-decode stage. Decodes the fetched word, reads operands
// with a writeback bypass, stalls on scoreboard hazards and drives the ID/EX register.
module id_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        fs_valid,
    input  logic [31:0] fs_inst,
    input  logic [31:0] fs_pc,
    output logic        ds_ready,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    input  logic        wb_we,
    input  logic [4:0]  wb_waddr,
    input  logic [31:0] wb_wdata,
    input  logic        flush,
    output logic        es_valid,
    input  logic        es_ready,
    output logic [31:0] es_pc,
    output logic [31:0] es_src1,
    output logic [31:0] es_src2,
    output logic [31:0] es_store_data,
    output logic [4:0]  es_dest,
    output logic        es_we,
    output logic [3:0]  es_alu_op,
    output logic        es_mem_re,
    output logic        es_mem_we
);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2a;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_SLT = 4'd4,
        ALU_SLL = 4'd5,
        ALU_LUI = 4'd6
    } alu_op_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] store_data;
        logic [4:0]  dest;
        logic        we;
        alu_op_e     alu_op;
        logic        mem_re;
        logic        mem_we;
    } issue_t;

    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [31:0] simm;

    assign op    = fs_inst[31:26];
    assign rs    = fs_inst[25:21];
    assign rt    = fs_inst[20:16];
    assign rd    = fs_inst[15:11];
    assign shamt = fs_inst[10:6];
    assign funct = fs_inst[5:0];
    assign imm   = fs_inst[15:0];
    assign simm  = {{16{imm[15]}}, imm};

    assign rf_raddr1 = rs;
    assign rf_raddr2 = rt;

    // One-hot of the register writeback commits this cycle; drives both bypass and clear.
    logic [31:0] wb_hit;
    logic [31:0] rs_val;
    logic [31:0] rt_val;

    assign wb_hit = wb_we ? (32'd1 << wb_waddr) : 32'd0;
    assign rs_val = (wb_hit[rs] && (rs != 5'd0)) ? wb_wdata : rf_rdata1;
    assign rt_val = (wb_hit[rt] && (rt != 5'd0)) ? wb_wdata : rf_rdata2;

    issue_t dec;
    logic   use_rs;
    logic   use_rt;
    logic   dec_wr;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        dec    = '0;
        dec.pc = fs_pc;
        use_rs = 1'b0;
        use_rt = 1'b0;
        dec_wr = 1'b0;
        case (op)
            OP_SPECIAL: begin
                case (funct)
                    FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT: begin
                        dec.src1 = rs_val;
                        dec.src2 = rt_val;
                        dec.dest = rd;
                        dec_wr   = 1'b1;
                        use_rs   = 1'b1;
                        use_rt   = 1'b1;
                        case (funct)
                            FN_SUBU: dec.alu_op = ALU_SUB;
                            FN_AND:  dec.alu_op = ALU_AND;
                            FN_OR:   dec.alu_op = ALU_OR;
                            FN_SLT:  dec.alu_op = ALU_SLT;
                            default: dec.alu_op = ALU_ADD;
                        endcase
                    end
                    FN_SLL: begin
                        dec.src1   = {27'd0, shamt};
                        dec.src2   = rt_val;
                        dec.dest   = rd;
                        dec.alu_op = ALU_SLL;
                        dec_wr     = 1'b1;
                        use_rt     = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_ADDIU, OP_LW: begin
                dec.src1   = rs_val;
                dec.src2   = simm;
                dec.dest   = rt;
                dec.mem_re = (op == OP_LW);
                dec_wr     = 1'b1;
                use_rs     = 1'b1;
            end
            OP_LUI: begin
                dec.src2   = {imm, 16'd0};
                dec.dest   = rt;
                dec.alu_op = ALU_LUI;
                dec_wr     = 1'b1;
            end
            OP_SW: begin
                dec.src1       = rs_val;
                dec.src2       = simm;
                dec.store_data = rt_val;
                dec.mem_we     = 1'b1;
                use_rs         = 1'b1;
                use_rt         = 1'b1;
            end
            default: ;
        endcase
        dec.we = dec_wr && (dec.dest != 5'd0);
    end

    // Scoreboard: bit 0 is forced low so r0 never stalls anything.
    logic [31:0] busy_q;
    logic [31:0] busy_d;
    logic        es_valid_q;
    logic        es_valid_d;
    issue_t      es_q;
    issue_t      es_d;

    logic raw;
    logic waw;
    logic issue;

    assign raw = (use_rs && busy_q[rs] && !wb_hit[rs]) ||
                 (use_rt && busy_q[rt] && !wb_hit[rt]);
    assign waw = dec.we && busy_q[dec.dest] && !wb_hit[dec.dest];

    assign ds_ready = !(raw || waw) && (!es_valid_q || es_ready) && !flush;
    assign issue    = fs_valid && ds_ready;

    always_comb begin
        es_valid_d = es_valid_q;
        es_d       = es_q;
        if (flush) begin
            es_valid_d = 1'b0;
        end else if (issue) begin
            es_valid_d = 1'b1;
            es_d       = dec;
        end else if (es_ready) begin
            es_valid_d = 1'b0;
        end
        // Set is applied after clear so a same-cycle set and clear leaves the bit set.
        busy_d = ((busy_q & ~wb_hit) |
                  ((issue && dec.we) ? (32'd1 << dec.dest) : 32'd0)) & ~32'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (!resetn) begin
            es_valid_q <= 1'b0;
            es_q       <= '0;
            busy_q     <= '0;
        end else begin
            es_valid_q <= es_valid_d;
            es_q       <= es_d;
            busy_q     <= busy_d;
        end
    end

    assign es_valid      = es_valid_q;
    assign es_pc         = es_q.pc;
    assign es_src1       = es_q.src1;
    assign es_src2       = es_q.src2;
    assign es_store_data = es_q.store_data;
    assign es_dest       = es_q.dest;
    assign es_we         = es_q.we;
    assign es_alu_op     = es_q.alu_op;
    assign es_mem_re     = es_q.mem_re;
    assign es_mem_we     = es_q.mem_we;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: table vectors, hand-written hazard/flush/reset sequences and a
// randomized run checked against a scoreboard-level reference model.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        fs_valid;
    logic [31:0] fs_inst;
    logic [31:0] fs_pc;
    logic        ds_ready;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        flush;
    logic        es_valid;
    logic        es_ready;
    logic [31:0] es_pc;
    logic [31:0] es_src1;
    logic [31:0] es_src2;
    logic [31:0] es_store_data;
    logic [4:0]  es_dest;
    logic        es_we;
    logic [3:0]  es_alu_op;
    logic        es_mem_re;
    logic        es_mem_we;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .resetn(resetn),
        .fs_valid(fs_valid), .fs_inst(fs_inst), .fs_pc(fs_pc), .ds_ready(ds_ready),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .flush(flush), .es_valid(es_valid), .es_ready(es_ready),
        .es_pc(es_pc), .es_src1(es_src1), .es_src2(es_src2),
        .es_store_data(es_store_data), .es_dest(es_dest), .es_we(es_we),
        .es_alu_op(es_alu_op), .es_mem_re(es_mem_re), .es_mem_we(es_mem_we)
    );

    // Register file environment: combinational read, write on the clock edge.
    logic [31:0] rf [32];
    assign rf_rdata1 = (rf_raddr1 == 5'd0) ? 32'd0 : rf[rf_raddr1];
    assign rf_rdata2 = (rf_raddr2 == 5'd0) ? 32'd0 : rf[rf_raddr2];
    always @(posedge clk) if (wb_we && wb_waddr != 5'd0) rf[wb_waddr] <= wb_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] r_type(input logic [5:0] fn, input logic [4:0] s,
                                           input logic [4:0] t, input logic [4:0] d,
                                           input logic [4:0] sh);
        return {6'h00, s, t, d, sh, fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] opc, input logic [4:0] s,
                                           input logic [4:0] t, input logic [15:0] im);
        return {opc, s, t, im};
    endfunction

    task automatic present(input logic [31:0] inst, input logic [31:0] pc);
        fs_valid = 1'b1;
        fs_inst  = inst;
        fs_pc    = pc;
    endtask

    task automatic release_reg(input logic [4:0] r, input logic [31:0] d);
        fs_valid = 1'b0;
        wb_we    = 1'b1;
        wb_waddr = r;
        wb_wdata = d;
        step();
        wb_we    = 1'b0;
    endtask

    // ---------------- reference model ----------------
    typedef enum {K_ADDU, K_SUBU, K_AND, K_OR, K_SLT, K_SLL,
                  K_ADDIU, K_LUI, K_LW, K_SW, K_NOP} kind_e;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] store;
        logic [4:0]  dest;
        logic        we;
        logic [3:0]  alu;
        logic        re;
        logic        mw;
        logic        u1;
        logic        u2;
    } exp_t;

    function automatic kind_e classify(input logic [31:0] inst);
        case (inst[31:26])
            6'h00: case (inst[5:0])
                       6'h21: return K_ADDU;
                       6'h23: return K_SUBU;
                       6'h24: return K_AND;
                       6'h25: return K_OR;
                       6'h2a: return K_SLT;
                       6'h00: return K_SLL;
                       default: return K_NOP;
                   endcase
            6'h09: return K_ADDIU;
            6'h0f: return K_LUI;
            6'h23: return K_LW;
            6'h2b: return K_SW;
            default: return K_NOP;
        endcase
    endfunction

    // Register value the decode stage should see: writeback wins over the stale file.
    function automatic logic [31:0] reg_val(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (wb_we && wb_waddr == r) return wb_wdata;
        return rf[r];
    endfunction

    function automatic exp_t model_decode(input logic [31:0] inst, input logic [31:0] pc);
        exp_t        e;
        kind_e       k    = classify(inst);
        logic [31:0] a    = reg_val(inst[25:21]);
        logic [31:0] b    = reg_val(inst[20:16]);
        logic [31:0] simm = {{16{inst[15]}}, inst[15:0]};
        e = '{default: 0};
        e.pc = pc;
        case (k)
            K_ADDU, K_SUBU, K_AND, K_OR, K_SLT: begin
                e.src1 = a; e.src2 = b; e.dest = inst[15:11]; e.u1 = 1; e.u2 = 1;
                e.alu = (k == K_SUBU) ? 4'd1 : (k == K_AND) ? 4'd2 :
                        (k == K_OR)   ? 4'd3 : (k == K_SLT) ? 4'd4 : 4'd0;
            end
            K_SLL:   begin e.src1 = {27'd0, inst[10:6]}; e.src2 = b; e.dest = inst[15:11];
                           e.u2 = 1; e.alu = 4'd5; end
            K_ADDIU: begin e.src1 = a; e.src2 = simm; e.dest = inst[20:16]; e.u1 = 1; end
            K_LW:    begin e.src1 = a; e.src2 = simm; e.dest = inst[20:16]; e.u1 = 1; e.re = 1; end
            K_LUI:   begin e.src2 = {inst[15:0], 16'd0}; e.dest = inst[20:16]; e.alu = 4'd6; end
            K_SW:    begin e.src1 = a; e.src2 = simm; e.store = b; e.u1 = 1; e.u2 = 1; e.mw = 1; end
            default: ;
        endcase
        e.we = (k != K_SW) && (k != K_NOP) && (e.dest != 5'd0);
        return e;
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [4:0]  a  = 5'($urandom_range(0, 7));
        logic [4:0]  b  = 5'($urandom_range(0, 7));
        logic [4:0]  c  = 5'($urandom_range(0, 7));
        logic [15:0] im = 16'($urandom);
        case ($urandom_range(0, 11))
            0:  return r_type(6'h21, a, b, c, 5'd0);
            1:  return r_type(6'h23, a, b, c, 5'd0);
            2:  return r_type(6'h24, a, b, c, 5'd0);
            3:  return r_type(6'h25, a, b, c, 5'd0);
            4:  return r_type(6'h2a, a, b, c, 5'd0);
            5:  return r_type(6'h00, a, b, c, 5'($urandom));
            6:  return i_type(6'h09, a, b, im);
            7:  return i_type(6'h0f, a, b, im);
            8:  return i_type(6'h23, a, b, im);
            9:  return i_type(6'h2b, a, b, im);
            10: return i_type(6'h3f, a, b, im);
            default: return r_type(6'h3f, a, b, c, 5'd0);
        endcase
    endfunction

    typedef struct {
        logic [31:0] inst;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] store;
        logic [4:0]  dest;
        logic        we;
        logic [3:0]  alu;
        logic        re;
        logic        mw;
    } vec_t;

    vec_t vecs [14];

    bit          pend [32];
    int          wbq [$];
    logic        ev;
    logic        hold;
    logic        iss;
    logic        exp_rdy;
    logic        haz;
    exp_t        cur;
    exp_t        held;

    initial begin
        vecs[0]  = '{i_type(6'h3f, 5'd9, 5'd9, 16'h1234), 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0};
        vecs[1]  = '{r_type(6'h21, 5'd8, 5'd9, 5'd11, 5'd0), 32'h10, 32'hFFFFFFF0, 32'h0, 5'd11, 1'b1, 4'd0, 1'b0, 1'b0};
        vecs[2]  = '{r_type(6'h23, 5'd9, 5'd8, 5'd12, 5'd0), 32'hFFFFFFF0, 32'h10, 32'h0, 5'd12, 1'b1, 4'd1, 1'b0, 1'b0};
        vecs[3]  = '{r_type(6'h24, 5'd10, 5'd9, 5'd13, 5'd0), 32'h80000001, 32'hFFFFFFF0, 32'h0, 5'd13, 1'b1, 4'd2, 1'b0, 1'b0};
        vecs[4]  = '{r_type(6'h25, 5'd8, 5'd10, 5'd14, 5'd0), 32'h10, 32'h80000001, 32'h0, 5'd14, 1'b1, 4'd3, 1'b0, 1'b0};
        vecs[5]  = '{r_type(6'h2a, 5'd9, 5'd8, 5'd15, 5'd0), 32'hFFFFFFF0, 32'h10, 32'h0, 5'd15, 1'b1, 4'd4, 1'b0, 1'b0};
        vecs[6]  = '{r_type(6'h00, 5'd0, 5'd10, 5'd16, 5'd4), 32'h4, 32'h80000001, 32'h0, 5'd16, 1'b1, 4'd5, 1'b0, 1'b0};
        vecs[7]  = '{i_type(6'h09, 5'd8, 5'd17, 16'hFFFE), 32'h10, 32'hFFFFFFFE, 32'h0, 5'd17, 1'b1, 4'd0, 1'b0, 1'b0};
        vecs[8]  = '{i_type(6'h0f, 5'd0, 5'd18, 16'hABCD), 32'h0, 32'hABCD0000, 32'h0, 5'd18, 1'b1, 4'd6, 1'b0, 1'b0};
        vecs[9]  = '{i_type(6'h23, 5'd9, 5'd19, 16'h0004), 32'hFFFFFFF0, 32'h4, 32'h0, 5'd19, 1'b1, 4'd0, 1'b1, 1'b0};
        vecs[10] = '{i_type(6'h2b, 5'd8, 5'd10, 16'h8000), 32'h10, 32'hFFFF8000, 32'h80000001, 5'd0, 1'b0, 4'd0, 1'b0, 1'b1};
        vecs[11] = '{32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 4'd5, 1'b0, 1'b0};
        vecs[12] = '{r_type(6'h3f, 5'd8, 5'd9, 5'd20, 5'd0), 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0};
        vecs[13] = '{i_type(6'h09, 5'd8, 5'd0, 16'h0005), 32'h10, 32'h5, 32'h0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0};

        for (int i = 0; i < 32; i++) rf[i] <= $urandom;
        rf[8]  <= 32'h00000010;
        rf[9]  <= 32'hFFFFFFF0;
        rf[10] <= 32'h80000001;

        resetn = 1'b0; fs_valid = 1'b0; fs_inst = 32'h0; fs_pc = 32'h0;
        wb_we = 1'b0; wb_waddr = 5'd0; wb_wdata = 32'h0; flush = 1'b0; es_ready = 1'b1;
        #1;
        check("reset_es_valid", 32'(es_valid), 32'd0);
        check("reset_ds_ready", 32'(ds_ready), 32'd1);
        check("reset_es_pc", es_pc, 32'd0);
        check("reset_es_src2", es_src2, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        step();

        // ---- table-driven single-instruction vectors ----
        for (int i = 0; i < 14; i++) begin
            present(vecs[i].inst, 32'h400 + 32'(i) * 4);
            es_ready = 1'b1;
            #1;
            check($sformatf("v%0d_ds_ready", i), 32'(ds_ready), 32'd1);
            step();
            check($sformatf("v%0d_es_valid", i), 32'(es_valid), 32'd1);
            check($sformatf("v%0d_pc", i), es_pc, 32'h400 + 32'(i) * 4);
            check($sformatf("v%0d_src1", i), es_src1, vecs[i].src1);
            check($sformatf("v%0d_src2", i), es_src2, vecs[i].src2);
            check($sformatf("v%0d_store", i), es_store_data, vecs[i].store);
            check($sformatf("v%0d_dest", i), 32'(es_dest), 32'(vecs[i].dest));
            check($sformatf("v%0d_we", i), 32'(es_we), 32'(vecs[i].we));
            check($sformatf("v%0d_alu", i), 32'(es_alu_op), 32'(vecs[i].alu));
            check($sformatf("v%0d_mem", i), 32'({es_mem_re, es_mem_we}), 32'({vecs[i].re, vecs[i].mw}));
            if (vecs[i].we) release_reg(vecs[i].dest, 32'h0);
            else begin fs_valid = 1'b0; step(); end
        end

        // ---- reset mid-stream ----
        present(i_type(6'h09, 5'd0, 5'd5, 16'h0001), 32'h500);
        es_ready = 1'b0;
        #1;
        step();
        fs_valid = 1'b0;
        check("rst_pre_es_valid", 32'(es_valid), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("rst_es_valid", 32'(es_valid), 32'd0);
        check("rst_es_pc", es_pc, 32'd0);
        check("rst_ds_ready", 32'(ds_ready), 32'd1);
        @(negedge clk);
        resetn = 1'b1;
        step();
        present(r_type(6'h21, 5'd5, 5'd5, 5'd6, 5'd0), 32'h504);
        es_ready = 1'b1;
        #1;
        check("rst_after_ready", 32'(ds_ready), 32'd1);
        step();
        check("rst_after_issue", 32'(es_valid), 32'd1);
        check("rst_after_dest", 32'(es_dest), 32'd6);
        release_reg(5'd6, 32'h0);

        // ---- RAW stall released by writeback bypass ----
        present(i_type(6'h09, 5'd0, 5'd5, 16'h8000), 32'h600);
        #1;
        step();
        check("raw_prod_src2", es_src2, 32'hFFFF8000);
        present(r_type(6'h21, 5'd5, 5'd5, 5'd6, 5'd0), 32'h604);
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("raw_stall%0d_ready", c), 32'(ds_ready), 32'd0);
            step();
            check($sformatf("raw_stall%0d_valid", c), 32'(es_valid), 32'd0);
        end
        wb_we = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'hFFFF8000;
        #1;
        check("raw_bypass_ready", 32'(ds_ready), 32'd1);
        step();
        wb_we = 1'b0;
        check("raw_cons_valid", 32'(es_valid), 32'd1);
        check("raw_cons_src1", es_src1, 32'hFFFF8000);
        check("raw_cons_src2", es_src2, 32'hFFFF8000);
        check("raw_cons_dest", 32'(es_dest), 32'd6);
        release_reg(5'd6, 32'h0);

        // ---- execute back-pressure holds the ID/EX register ----
        present(i_type(6'h0f, 5'd0, 5'd1, 16'h1234), 32'h700);
        es_ready = 1'b0;
        #1;
        step();
        present(i_type(6'h09, 5'd0, 5'd3, 16'h0007), 32'h704);
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("bp%0d_ready", c), 32'(ds_ready), 32'd0);
            check($sformatf("bp%0d_valid", c), 32'(es_valid), 32'd1);
            check($sformatf("bp%0d_src2", c), es_src2, 32'h12340000);
            check($sformatf("bp%0d_pc", c), es_pc, 32'h700);
            step();
        end
        es_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(ds_ready), 32'd1);
        step();
        check("bp_next_dest", 32'(es_dest), 32'd3);
        check("bp_next_src2", es_src2, 32'h7);
        release_reg(5'd1, 32'h0);
        release_reg(5'd3, 32'h0);

        // ---- WAW and same-cycle set/clear ----
        present(i_type(6'h09, 5'd0, 5'd2, 16'h0001), 32'h800);
        #1;
        step();
        present(i_type(6'h09, 5'd0, 5'd2, 16'h0002), 32'h804);
        #1;
        check("waw_stall_ready", 32'(ds_ready), 32'd0);
        step();
        check("waw_stall2_ready", 32'(ds_ready), 32'd0);
        wb_we = 1'b1; wb_waddr = 5'd2; wb_wdata = 32'h1;
        #1;
        check("waw_clear_ready", 32'(ds_ready), 32'd1);
        step();
        wb_we = 1'b0;
        check("waw_issue_src2", es_src2, 32'h2);
        present(r_type(6'h21, 5'd2, 5'd0, 5'd7, 5'd0), 32'h808);
        #1;
        check("waw_busy_kept", 32'(ds_ready), 32'd0);
        step();
        check("waw_busy_valid", 32'(es_valid), 32'd0);
        wb_we = 1'b1; wb_waddr = 5'd2; wb_wdata = 32'h2;
        #1;
        check("waw_final_ready", 32'(ds_ready), 32'd1);
        step();
        wb_we = 1'b0;
        check("waw_final_src1", es_src1, 32'h2);
        release_reg(5'd7, 32'h0);

        // ---- flush ----
        present(i_type(6'h09, 5'd0, 5'd3, 16'h0005), 32'h900);
        es_ready = 1'b0;
        #1;
        step();
        check("fl_pre_valid", 32'(es_valid), 32'd1);
        present(i_type(6'h09, 5'd0, 5'd4, 16'h0006), 32'h904);
        es_ready = 1'b1;
        flush = 1'b1;
        #1;
        check("fl_ready", 32'(ds_ready), 32'd0);
        step();
        flush = 1'b0;
        check("fl_valid", 32'(es_valid), 32'd0);
        #1;
        check("fl_next_ready", 32'(ds_ready), 32'd1);
        step();
        check("fl_next_valid", 32'(es_valid), 32'd1);
        check("fl_next_dest", 32'(es_dest), 32'd4);
        check("fl_next_src2", es_src2, 32'h6);
        release_reg(5'd3, 32'h0);
        release_reg(5'd4, 32'h0);
        step();

        // ---- randomized run against the reference model ----
        for (int i = 0; i < 32; i++) pend[i] = 1'b0;
        ev   = 1'b0;
        hold = 1'b0;
        held = '{default: 0};
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!hold) begin
                fs_valid = ($urandom_range(0, 3) != 0);
                fs_inst  = gen_inst();
                fs_pc    = $urandom;
            end
            es_ready = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 15) == 0);
            if (wbq.size() > 0 && $urandom_range(0, 2) == 0) begin
                wb_we    = 1'b1;
                wb_waddr = 5'(wbq.pop_front());
                wb_wdata = $urandom;
            end else begin
                wb_we = 1'b0;
            end
            #1;
            cur = model_decode(fs_inst, fs_pc);
            haz = (cur.u1 && pend[fs_inst[25:21]] && !(wb_we && wb_waddr == fs_inst[25:21])) ||
                  (cur.u2 && pend[fs_inst[20:16]] && !(wb_we && wb_waddr == fs_inst[20:16])) ||
                  (cur.we && pend[cur.dest] && !(wb_we && wb_waddr == cur.dest));
            exp_rdy = !haz && (!ev || es_ready) && !flush;
            check("rnd_ds_ready", 32'(ds_ready), 32'(exp_rdy));
            iss = fs_valid && exp_rdy;
            step();
            if (wb_we) pend[wb_waddr] = 1'b0;
            if (flush) ev = 1'b0;
            else if (iss) begin
                ev   = 1'b1;
                held = cur;
                if (cur.we) begin
                    pend[cur.dest] = 1'b1;
                    wbq.push_back(int'(cur.dest));
                end
            end else if (es_ready) ev = 1'b0;
            hold = fs_valid && !iss;
            check("rnd_es_valid", 32'(es_valid), 32'(ev));
            if (ev) begin
                check("rnd_pc", es_pc, held.pc);
                check("rnd_src1", es_src1, held.src1);
                check("rnd_src2", es_src2, held.src2);
                check("rnd_store", es_store_data, held.store);
                check("rnd_dest_we", 32'({es_dest, es_we}), 32'({held.dest, held.we}));
                check("rnd_alu_mem", 32'({es_alu_op, es_mem_re, es_mem_we}),
                      32'({held.alu, held.re, held.mw}));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
